// File: rtl/mmio_cmd_fifo.sv
// Host-to-control-unit MMIO command FIFO (first-word-fall-through) with registered status word.
// Optional saturating drop counter in status[15:8] when MMIO_CMD_FIFO_OVF_CNT_EN is defined.
module mmio_cmd_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] h2f_pio32,
  input  logic              h2f_write,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              ovf_clr,
  output logic [31:0]       f2h_pio32,
  output logic              f2h_write
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        ovf_cnt;
  logic [31:0]       status, stat_q;
  logic              stat_wr_q;
  logic              empty, full, pop, push_ok, ovf_evt;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign pop     = !empty && cmd_ready;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = h2f_write && (!full || pop);
  assign ovf_evt = h2f_write && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    // Head register tracks the next word; it holds its last value once the FIFO drains.
    if (count_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = h2f_pio32;
      else                                   head_d = mem_q[rd_ptr_d];
    end
    if (ovf_evt)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= head_d;
      if (push_ok) mem_q[wr_ptr_q] <= h2f_pio32;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MMIO_CMD_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= 8'h00;
    end else if (ovf_evt) begin
      if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'h01;
    end else if (ovf_clr) begin
      ovf_cnt_q <= 8'h00;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'h00;
`endif

  assign status = {ovf_q, empty, full, 13'b0, ovf_cnt, 1'b0, 7'(count_q)};

  // Status is sampled from the registered FIFO state, so it trails that state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q    <= 32'h4000_0000;
      stat_wr_q <= 1'b0;
    end else begin
      stat_q    <= status;
      stat_wr_q <= (status != stat_q);
    end
  end

  assign cmd_valid = !empty;
  assign cmd_data  = head_q;
  assign f2h_pio32 = stat_q;
  assign f2h_write = stat_wr_q;

endmodule

// File: tb/tb_mmio_cmd_fifo.sv
// Scoreboard bench for mmio_cmd_fifo: directed stimulus queues expected words, a monitor
// compares every popped word; status word checks use hand-computed constants.
module tb_mmio_cmd_fifo;

  localparam int unsigned DEPTH = 16;

`ifdef MMIO_CMD_FIFO_OVF_CNT_EN
  localparam logic [31:0] StFullOvf1 = 32'hA000_0110;
  localparam logic [31:0] StSat      = 32'hA000_FF10;
`else
  localparam logic [31:0] StFullOvf1 = 32'hA000_0010;
  localparam logic [31:0] StSat      = 32'hA000_0010;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] h2f_pio32 = '0;
  logic        h2f_write = 1'b0;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] f2h_pio32;
  logic        f2h_write;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_occ   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  mmio_cmd_fifo #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .h2f_pio32 (h2f_pio32),
    .h2f_write (h2f_write),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ovf_clr   (ovf_clr),
    .f2h_pio32 (f2h_pio32),
    .f2h_write (f2h_write)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must deliver the oldest expected word.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %h expected no word", cmd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cmd_data !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data: got %h expected %h", cmd_data, mon_exp);
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [31:0] d, input logic rdy, input logic clr);
    bit p, a;
    h2f_write = w;
    h2f_pio32 = d;
    cmd_ready = rdy;
    ovf_clr   = clr;
    p = (m_occ > 0) && rdy;
    a = w && ((m_occ != DEPTH) || p);
    if (a) exp_q.push_back(d);
    m_occ = m_occ + int'(a) - int'(p);
    @(posedge clk);
    #1;
    check32("cmd_valid", {31'b0, cmd_valid}, {31'b0, m_occ != 0});
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic w, input logic [31:0] d);
    rst       = 1'b1;
    h2f_write = w;
    h2f_pio32 = d;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    h2f_write = 1'b0;
    exp_q.delete();
    m_occ = 0;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0, 32'h0);
    do_reset(1'b0, 32'h0);
    check32("rst_valid", {31'b0, cmd_valid}, 32'h0);
    check32("rst_status", f2h_pio32, 32'h4000_0000);
    check32("rst_f2h_write", {31'b0, f2h_write}, 32'h0);

    // Single push, 1-cycle latency, status lags one more cycle with one pulse
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check32("first_data", cmd_data, 32'h1234_5678);
    idle();
    check32("first_status", f2h_pio32, 32'h0000_0001);
    check32("first_pulse", {31'b0, f2h_write}, 32'h1);
    idle();
    check32("first_pulse_once", {31'b0, f2h_write}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check32("data_held_empty", cmd_data, 32'h1234_5678);
    idle();
    check32("empty_status", f2h_pio32, 32'h4000_0000);

    // 17 pushes into DEPTH=16, then drain in order
    do_reset(1'b0, 32'h0);
    for (int i = 1; i <= 17; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    idle();
    check32("ovf17_status", f2h_pio32, StFullOvf1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check32("ovf17_drained", 32'(exp_q.size()), 32'h0);

    // Full with simultaneous push and pop
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h999, 1'b1, 1'b0);
    idle();
    check32("full_pushpop_status", f2h_pio32, 32'h2000_0010);
    for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check32("full_pushpop_drained", 32'(exp_q.size()), 32'h0);

    // Overflow with ovf_clr in the same cycle, then clear alone
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b1);
    idle();
    check32("ovf_set_wins", f2h_pio32, StFullOvf1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    check32("ovf_cleared", f2h_pio32, 32'h2000_0010);

    // Reset with words queued and a push in the reset cycle
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    idle();
    do_reset(1'b1, 32'hBAD0_0BAD);
    check32("flush_valid", {31'b0, cmd_valid}, 32'h0);
    check32("flush_status", f2h_pio32, 32'h4000_0000);
    check32("flush_f2h_write", {31'b0, f2h_write}, 32'h0);
    idle();
    check32("flush_no_pulse", {31'b0, f2h_write}, 32'h0);
    check32("flush_status2", f2h_pio32, 32'h4000_0000);

    // 300 overflowing pushes: counter saturates
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 316; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    idle();
    check32("ovf_saturate", f2h_pio32, StSat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_cmd_fifo.md
MMIO_CMD_FIFO -- requirements
Module: mmio_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; a power of 2 in the range 4..64.
REQ-002 SHALL have parameter DATA_W, default 32, meaning host word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port h2f_pio32, input, DATA_W bits: host MMIO write data.
REQ-006 SHALL have port h2f_write, input, 1 bit: push strobe; each high cycle is one word.
REQ-007 SHALL have port cmd_data, output, DATA_W bits: head word to the control unit.
REQ-008 SHALL have port cmd_valid, output, 1 bit: cmd_data holds a valid word.
REQ-009 SHALL have port cmd_ready, input, 1 bit: the control unit accepts the word.
REQ-010 SHALL have port ovf_clr, input, 1 bit: clears the overflow flag and the overflow counter.
REQ-011 SHALL have port f2h_pio32, output, 32 bits: registered status word to the host.
REQ-012 SHALL have port f2h_write, output, 1 bit: one-cycle pulse when f2h_pio32 changes.

Function
REQ-013 SHALL be a first-word-fall-through FIFO; pop occurs when cmd_valid && cmd_ready.
REQ-014 SHALL present a word pushed into an empty FIFO at edge t with cmd_valid=1 after edge t, i.e. 1-cycle latency; there is no same-cycle bypass.
REQ-015 SHALL hold cmd_data stable while cmd_valid=1 and cmd_ready=0.
REQ-016 SHALL keep cmd_data at its last value, not reset to zero, while cmd_valid=0 after reset.
REQ-017 SHALL track occupancy 0..DEPTH with a (log2(DEPTH)+1)-bit count; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL accept push and pop in the same cycle when full; occupancy is unchanged and no overflow occurs.
REQ-019 SHALL, on push when full without pop, drop the word, leave FIFO contents unchanged, and set sticky overflow.
REQ-020 SHALL ignore pop when empty, since cmd_valid=0.
REQ-021 SHALL, when overflow and ovf_clr occur in the same cycle, set overflow (set wins).
REQ-022 SHALL form the status word as: [31] overflow sticky, [30] empty, [29] full, [28:16] 0, [15:8] overflow count, [7] 0, [6:0] occupancy.
REQ-023 SHALL register f2h_pio32 from the post-edge state, so it lags the FIFO state by 1 cycle.
REQ-024 SHALL assert f2h_write for exactly 1 cycle, in the cycle after f2h_pio32 takes a value different from its previous value.

Reset
REQ-025 SHALL, when rst=1 at an edge, empty the FIFO, zero both pointers, clear overflow and the counter, set cmd_valid=0, f2h_pio32=32'h4000_0000 and f2h_write=0.
REQ-026 SHALL treat reset mid-operation as a flush: words in flight are discarded and h2f_write in the reset cycle is ignored.
REQ-027 SHALL generate no f2h_write pulse for the reset-value transition.

Configuration
REQ-028 SHALL support macro MMIO_CMD_FIFO_OVF_CNT_EN.
REQ-029 SHALL, when MMIO_CMD_FIFO_OVF_CNT_EN is defined, count dropped words in status[15:8], saturating at 255 and cleared by ovf_clr or rst.
REQ-030 SHALL, when MMIO_CMD_FIFO_OVF_CNT_EN is not defined, drive status[15:8] constant 0 and generate no counter flops; all other behaviour is identical.

Verification
REQ-031 SHALL cover: after reset, push 0x1234_5678 with cmd_ready=0 -> cmd_valid=1 next cycle, cmd_data=0x1234_5678, f2h_pio32 occupancy=1, one f2h_write pulse.
REQ-032 SHALL cover: 17 pushes with DEPTH=16 and cmd_ready=0 -> full=1, overflow=1, count=1 (macro on) or 0 (macro off); pops return words 1..16 in order.
REQ-033 SHALL cover: fill to full, then push and pop in the same cycle -> occupancy stays 16, overflow=0, next pop returns the new word last.
REQ-034 SHALL cover: overflow and ovf_clr in the same cycle -> overflow=1; ovf_clr alone next cycle -> overflow=0, count=0.
REQ-035 SHALL cover: rst=1 with 5 words queued and h2f_write=1 -> next cycle cmd_valid=0, f2h_pio32=0x4000_0000, f2h_write=0.
REQ-036 SHALL cover: 300 overflowing pushes with the macro on -> status[15:8]=255, with no wrap to 0.
